// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the K&S processor.
// It drives every datapath strobe and select from a registered state and paces RAM accesses.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    StRst,
    StFetch,
    StDecode,
    StMemRd,
    StMemWr,
    StAlu,
    StBr,
    StHalted
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            alu_flags_q, alu_flags_d;
  logic            last_cnt;
  logic            overflow;
  logic            taken;

  assign last_cnt = (wait_cnt_q == LastCnt);
  assign overflow = unsigned_overflow | signed_overflow;

  // ALU controls are captured leaving DECODE so ALU-cycle outputs depend only on registers.
  always_comb begin
    alu_op_d    = 2'b00;
    alu_flags_d = 1'b1;
    case (decoded_instruction)
      I_ADD:   alu_op_d = 2'b00;
      I_SUB:   alu_op_d = 2'b01;
      I_AND:   alu_op_d = 2'b10;
      I_OR:    alu_op_d = 2'b11;
      I_MOVE: begin
        alu_op_d    = 2'b11;
        alu_flags_d = 1'b0;
      end
      default: alu_op_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRst;
      wait_cnt_q  <= '0;
      alu_op_q    <= 2'b00;
      alu_flags_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_q == StDecode) begin
        alu_op_q    <= alu_op_d;
        alu_flags_q <= alu_flags_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch: begin
        if (last_cnt) state_d = StDecode;
        else          wait_cnt_d = wait_cnt_q + CntW'(1);
      end
      StDecode: begin
        case (decoded_instruction)
          I_LOAD:                                 state_d = StMemRd;
          I_STORE:                                state_d = StMemWr;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR:      state_d = StAlu;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:                 state_d = StBr;
          I_HALT:                                 state_d = StHalted;
          default:                                state_d = StFetch;
        endcase
      end
      StMemRd, StMemWr: begin
        if (last_cnt) state_d = StFetch;
        else          wait_cnt_d = wait_cnt_q + CntW'(1);
      end
      StAlu, StBr: state_d = StFetch;
      StHalted:    state_d = StHalted;
      default:     state_d = StRst;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = ~zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = ~neg_op;
      I_BOV:    taken = overflow;
      I_BNOV:   taken = ~overflow;
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state_q)
      StFetch:  ir_enable = last_cnt;
      StDecode: pc_enable = 1'b1;
      StMemRd: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = last_cnt;
      end
      StMemWr: begin
        addr_sel         = 1'b1;
        ram_write_enable = (wait_cnt_q == '0);
      end
      StAlu: begin
        operation        = alu_op_q;
        write_reg_enable = 1'b1;
        flags_reg_enable = alu_flags_q;
      end
      StBr: begin
        pc_enable = taken;
        branch    = taken;
      end
      StHalted: halt = 1'b1;
      default: ;
    endcase
  end

endmodule
